// File: rtl/ahb_master_seq.sv
// Command-driven AHB master: turns single/incrementing-burst commands into
// pipelined AHB address and data phases, with write-data fetch and read return.
module ahb_master_seq #(
  parameter int LEN_W = 4
) (
  input  logic             Hclk,
  input  logic             Hresetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [2:0]       cmd_size,
  input  logic [31:0]      wr_data,
  output logic             wr_pop,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  output logic             done,
  input  logic             Hreadyout,
  input  logic [31:0]      Hrdata,
  output logic             Hwrite,
  output logic             Hreadyin,
  output logic [1:0]       Htrans,
  output logic [2:0]       Hsize,
  output logic [2:0]       Hburst,
  output logic [31:0]      Haddr,
  output logic [31:0]      Hwdata,
  output logic [1:0]       dbg_state
);

  localparam int CW = LEN_W + 1;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    PIPE = 2'd2,
    LAST = 2'd3
  } state_t;

  state_t           state, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CW-1:0]    issued, issued_d;
  logic [CW-1:0]    completed, completed_d;

  logic [1:0]  htrans_d;
  logic [31:0] haddr_d, hwdata_d, rd_data_d;
  logic [2:0]  hsize_d, hburst_d;
  logic        hwrite_d, hreadyin_d, rd_valid_d, done_d;

  logic addr_acc, data_acc, last_addr, burst_end;

  function automatic logic [2:0] burst_code(input logic [LEN_W-1:0] len);
    logic [2:0] code;
    case (32'(len))
      0:       code = 3'b000;
      3:       code = 3'b011;
      7:       code = 3'b101;
      15:      code = 3'b111;
      default: code = 3'b001;
    endcase
    return code;
  endfunction

  // Command handshake: a command transfers on a rising edge where
  // cmd_valid && cmd_ready; cmd_ready is high only in IDLE and the requester
  // holds cmd_valid and all cmd_* fields stable until that edge.
  assign cmd_ready = (state == IDLE);
  assign dbg_state = state;

  // Htrans is non-IDLE only in ADDR/PIPE, so this is the address-phase handoff.
  assign addr_acc  = Htrans[1] && Hreadyout;
  assign data_acc  = ((state == PIPE) || (state == LAST)) && Hreadyout;
  assign wr_pop    = addr_acc && Hwrite;
  assign last_addr = (issued == {1'b0, len_q});
  assign burst_end = (completed == {1'b0, len_q});

  always_comb begin
    state_d     = state;
    len_d       = len_q;
    issued_d    = issued;
    completed_d = completed;
    htrans_d    = Htrans;
    haddr_d     = Haddr;
    hwrite_d    = Hwrite;
    hsize_d     = Hsize;
    hburst_d    = Hburst;
    hreadyin_d  = Hreadyin;
    hwdata_d    = Hwdata;
    rd_data_d   = rd_data;
    rd_valid_d  = 1'b0;
    done_d      = 1'b0;

    if (wr_pop) hwdata_d = wr_data;

    if (data_acc) begin
      completed_d = completed + CW'(1);
      if (!Hwrite) begin
        rd_data_d  = Hrdata;
        rd_valid_d = 1'b1;
      end
    end

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_d     = ADDR;
          len_d       = cmd_len;
          issued_d    = '0;
          completed_d = '0;
          htrans_d    = TRANS_NONSEQ;
          haddr_d     = cmd_addr;
          hwrite_d    = cmd_write;
          hsize_d     = (cmd_size > 3'd2) ? 3'd2 : cmd_size;
          hburst_d    = burst_code(cmd_len);
          hreadyin_d  = 1'b1;
        end
      end
      ADDR, PIPE: begin
        if (addr_acc) begin
          issued_d = issued + CW'(1);
          haddr_d  = Haddr + (32'd1 << Hsize);
          if (last_addr) begin
            state_d  = LAST;
            htrans_d = TRANS_IDLE;
          end else begin
            state_d  = PIPE;
            htrans_d = TRANS_SEQ;
          end
        end
      end
      LAST: begin
        if (Hreadyout && burst_end) begin
          state_d    = IDLE;
          hreadyin_d = 1'b0;
          done_d     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      state     <= IDLE;
      len_q     <= '0;
      issued    <= '0;
      completed <= '0;
      Htrans    <= TRANS_IDLE;
      Haddr     <= '0;
      Hwrite    <= 1'b0;
      Hsize     <= '0;
      Hburst    <= '0;
      Hreadyin  <= 1'b0;
      Hwdata    <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      len_q     <= len_d;
      issued    <= issued_d;
      completed <= completed_d;
      Htrans    <= htrans_d;
      Haddr     <= haddr_d;
      Hwrite    <= hwrite_d;
      Hsize     <= hsize_d;
      Hburst    <= hburst_d;
      Hreadyin  <= hreadyin_d;
      Hwdata    <= hwdata_d;
      rd_data   <= rd_data_d;
      rd_valid  <= rd_valid_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_ahb_master_seq.sv
// Self-checking bench for ahb_master_seq: a step-level AHB pipeline model
// predicts every cycle of each command, plus literal checks of key cycles.
module tb_ahb_master_seq;

  localparam int LEN_W = 4;
  localparam int MAXC  = 64;

  logic             Hclk, Hresetn;
  logic             cmd_valid, cmd_ready, cmd_write;
  logic [31:0]      cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic [2:0]       cmd_size;
  logic [31:0]      wr_data, rd_data, Hrdata, Haddr, Hwdata;
  logic             wr_pop, rd_valid, done, Hreadyout, Hwrite, Hreadyin;
  logic [1:0]       Htrans, dbg_state;
  logic [2:0]       Hsize, Hburst;

  ahb_master_seq #(.LEN_W(LEN_W)) dut (
    .Hclk(Hclk), .Hresetn(Hresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .wr_data(wr_data), .wr_pop(wr_pop), .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .Hreadyout(Hreadyout), .Hrdata(Hrdata), .Hwrite(Hwrite),
    .Hreadyin(Hreadyin), .Htrans(Htrans), .Hsize(Hsize), .Hburst(Hburst),
    .Haddr(Haddr), .Hwdata(Hwdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] wd[16];
  logic [31:0] rd[16];
  bit          rdy[MAXC];

  logic [1:0]  e_trans[MAXC];
  logic [31:0] e_addr[MAXC], e_wdata[MAXC];
  bit          e_actl[MAXC], e_ctl[MAXC], e_wchk[MAXC], e_pop[MAXC];
  bit          e_rv[MAXC], e_done[MAXC], e_cmdrdy[MAXC], e_hri[MAXC];
  logic        e_write;
  logic [2:0]  e_size, e_burst;
  int          last_cyc;

  logic [1:0]  log_trans[MAXC];
  logic [2:0]  log_burst[MAXC], log_size[MAXC];
  logic [31:0] log_addr[MAXC], log_wdata[MAXC], log_rdata[MAXC];
  bit          log_pop[MAXC], log_rv[MAXC], log_done[MAXC], log_hw[MAXC], log_hri[MAXC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Bus progress is a sequence of N+1 steps: step k carries address beat k
  // (k<N) and data beat k-1 (k>0); each step ends on the first ready cycle.
  task automatic build_model(input bit write, input logic [31:0] addr,
                             input int len, input int size);
    int n, c, st;
    logic [31:0] inc;
    for (int i = 0; i < MAXC; i++) begin
      e_trans[i] = 2'b00; e_addr[i] = '0; e_wdata[i] = '0;
      e_actl[i] = 0; e_ctl[i] = 0; e_wchk[i] = 0; e_pop[i] = 0;
      e_rv[i] = 0; e_done[i] = 0; e_cmdrdy[i] = 0; e_hri[i] = 0;
    end
    exp_q.delete();
    n = len + 1;
    e_size = (size > 2) ? 3'd2 : 3'(size);
    inc = 32'd1 << e_size;
    e_write = write;
    case (len)
      0: e_burst = 3'b000;
      3: e_burst = 3'b011;
      7: e_burst = 3'b101;
      15: e_burst = 3'b111;
      default: e_burst = 3'b001;
    endcase
    e_cmdrdy[0] = 1;
    c = 1;
    for (int k = 0; k <= n; k++) begin
      st = c;
      while (!rdy[c] && c < MAXC - 4) c++;
      for (int t = st; t <= c; t++) begin
        e_ctl[t] = 1;
        e_hri[t] = 1;
        if (k < n) begin
          e_trans[t] = (k == 0) ? 2'b10 : 2'b11;
          e_actl[t]  = 1;
          e_addr[t]  = addr + 32'(k) * inc;
        end
        if (k > 0 && write) begin
          e_wchk[t]  = 1;
          e_wdata[t] = wd[k-1];
        end
      end
      if (k < n && write) e_pop[c] = 1;
      if (k > 0 && !write) begin
        e_rv[c+1] = 1;
        exp_q.push_back(rd[k-1]);
      end
      c++;
    end
    e_done[c] = 1;
    e_cmdrdy[c] = 1;
    e_cmdrdy[c+1] = 1;
    last_cyc = c + 1;
  endtask

  // ---------------- compare (one point, every cycle) ----------------
  task automatic compare_cycle(input int c);
    log_trans[c] = Htrans; log_addr[c] = Haddr; log_wdata[c] = Hwdata;
    log_rdata[c] = rd_data; log_pop[c] = wr_pop; log_rv[c] = rd_valid;
    log_done[c] = done; log_burst[c] = Hburst; log_size[c] = Hsize;
    log_hw[c] = Hwrite; log_hri[c] = Hreadyin;
    chk($sformatf("c%0d Htrans", c), 32'(Htrans), 32'(e_trans[c]));
    chk($sformatf("c%0d cmd_ready", c), 32'(cmd_ready), 32'(e_cmdrdy[c]));
    chk($sformatf("c%0d Hreadyin", c), 32'(Hreadyin), 32'(e_hri[c]));
    chk($sformatf("c%0d wr_pop", c), 32'(wr_pop), 32'(e_pop[c]));
    chk($sformatf("c%0d rd_valid", c), 32'(rd_valid), 32'(e_rv[c]));
    chk($sformatf("c%0d done", c), 32'(done), 32'(e_done[c]));
    if (e_actl[c]) chk($sformatf("c%0d Haddr", c), Haddr, e_addr[c]);
    if (e_ctl[c]) begin
      chk($sformatf("c%0d Hwrite", c), 32'(Hwrite), 32'(e_write));
      chk($sformatf("c%0d Hsize", c), 32'(Hsize), 32'(e_size));
      chk($sformatf("c%0d Hburst", c), 32'(Hburst), 32'(e_burst));
    end
    if (e_wchk[c]) chk($sformatf("c%0d Hwdata", c), Hwdata, e_wdata[c]);
    if (rd_valid) begin
      if (exp_q.size() == 0) chk($sformatf("c%0d rd_extra", c), 32'd1, 32'd0);
      else chk($sformatf("c%0d rd_data", c), rd_data, exp_q.pop_front());
    end
  endtask

  // ---------------- driver ----------------
  // Requester FIFO supplies wr_data[pop_idx]; slave returns rd[dp_idx] in data phases.
  task automatic run_cmd(input bit write, input logic [31:0] addr, input int len,
                         input int size, input int ws, input int wn, input bit junk);
    int pop_idx, dp_idx;
    bit dp_active;
    for (int c = 0; c < MAXC; c++) rdy[c] = !(c >= ws && c < ws + wn);
    build_model(write, addr, len, size);
    pop_idx = 0; dp_idx = 0; dp_active = 0;
    for (int cyc = 0; cyc <= last_cyc; cyc++) begin
      cmd_valid = (cyc == 0) || (junk && cyc >= 2 && cyc <= 4);
      cmd_write = (cyc == 0) ? write : !write;
      cmd_addr  = (cyc == 0) ? addr : 32'h5555_0000;
      cmd_len   = (cyc == 0) ? LEN_W'(len) : '1;
      cmd_size  = (cyc == 0) ? 3'(size) : 3'd1;
      Hreadyout = rdy[cyc];
      wr_data   = wd[pop_idx];
      Hrdata    = dp_active ? rd[dp_idx] : 32'hDEAD_BEEF;
      @(negedge Hclk);
      compare_cycle(cyc);
      if (wr_pop && pop_idx < 15) pop_idx++;
      if (Hreadyout) begin
        if (dp_active && dp_idx < 15) dp_idx++;
        dp_active = (Htrans != 2'b00);
      end
      @(posedge Hclk); #1;
    end
    cmd_valid = 1'b0;
    Hreadyout = 1'b1;
    chk("rd_queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic int first_done();
    for (int c = 0; c <= last_cyc; c++) if (log_done[c]) return c;
    return -1;
  endfunction

  function automatic int count_rv();
    int n = 0;
    for (int c = 0; c <= last_cyc; c++) if (log_rv[c]) n++;
    return n;
  endfunction

  function automatic int count_pop();
    int n = 0;
    for (int c = 0; c <= last_cyc; c++) if (log_pop[c]) n++;
    return n;
  endfunction

  task automatic fill_data(input logic [31:0] wbase, input logic [31:0] rbase);
    for (int k = 0; k < 16; k++) begin
      wd[k] = wbase + 32'(k) * 32'h0101_0101;
      rd[k] = rbase + 32'(k);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " Htrans"}, 32'(Htrans), 32'd0);
    chk({tag, " Hwrite"}, 32'(Hwrite), 32'd0);
    chk({tag, " Haddr"}, Haddr, 32'd0);
    chk({tag, " Hwdata"}, Hwdata, 32'd0);
    chk({tag, " Hsize"}, 32'(Hsize), 32'd0);
    chk({tag, " Hburst"}, 32'(Hburst), 32'd0);
    chk({tag, " Hreadyin"}, 32'(Hreadyin), 32'd0);
    chk({tag, " rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, " rd_data"}, rd_data, 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " wr_pop"}, 32'(wr_pop), 32'd0);
    chk({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, " dbg_state"}, 32'(dbg_state), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] got[$];
    Hresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_len = '0; cmd_size = '0; wr_data = '0; Hreadyout = 1'b1; Hrdata = '0;
    repeat (3) @(posedge Hclk);
    #1;
    @(negedge Hclk);
    check_all_zero("reset");
    Hresetn = 1'b1;
    @(posedge Hclk); #1;

    // 1: single byte write
    fill_data(32'h0, 32'h0);
    wd[0] = 32'h0000_00A3;
    run_cmd(1'b1, 32'h8000_0001, 0, 0, 0, 0, 1'b0);
    chk("t1 c1 Htrans", 32'(log_trans[1]), 32'h2);
    chk("t1 c1 Hburst", 32'(log_burst[1]), 32'h0);
    chk("t1 c1 Haddr", log_addr[1], 32'h8000_0001);
    chk("t1 c1 wr_pop", 32'(log_pop[1]), 32'd1);
    chk("t1 c2 Htrans", 32'(log_trans[2]), 32'h0);
    chk("t1 c2 Hwdata", log_wdata[2], 32'h0000_00A3);
    chk("t1 c3 done", 32'(log_done[3]), 32'd1);
    chk("t1 c3 Hreadyin", 32'(log_hri[3]), 32'd0);

    // 2: single read
    fill_data(32'h0, 32'h1234_5678);
    run_cmd(1'b0, 32'h8000_00A2, 0, 1, 0, 0, 1'b0);
    chk("t2 c1 Hwrite", 32'(log_hw[1]), 32'd0);
    chk("t2 c3 rd_valid", 32'(log_rv[3]), 32'd1);
    chk("t2 c3 rd_data", log_rdata[3], 32'h1234_5678);
    chk("t2 done cycle", 32'(first_done()), 32'd3);

    // 3: INCR4 word write, stray cmd_valid mid-burst must be ignored
    fill_data(32'h1111_0000, 32'h0);
    run_cmd(1'b1, 32'h8000_0010, 3, 2, 0, 0, 1'b1);
    chk("t3 Haddr b0", log_addr[1], 32'h8000_0010);
    chk("t3 Haddr b1", log_addr[2], 32'h8000_0014);
    chk("t3 Haddr b2", log_addr[3], 32'h8000_0018);
    chk("t3 Haddr b3", log_addr[4], 32'h8000_001C);
    chk("t3 Htrans b1", 32'(log_trans[2]), 32'h3);
    chk("t3 Htrans last", 32'(log_trans[5]), 32'h0);
    chk("t3 Hburst", 32'(log_burst[1]), 32'h3);
    chk("t3 Hwdata b3", log_wdata[5], 32'h1414_0303);
    chk("t3 pop count", 32'(count_pop()), 32'd4);
    chk("t3 done cycle", 32'(first_done()), 32'd6);

    // 4: INCR4 read with two wait states in cycles 3-4
    fill_data(32'h0, 32'hA000_0001);
    run_cmd(1'b0, 32'h8000_0040, 3, 2, 3, 2, 1'b0);
    chk("t4 Haddr hold c3", log_addr[3], 32'h8000_0048);
    chk("t4 Haddr hold c4", log_addr[4], 32'h8000_0048);
    chk("t4 Htrans hold c4", 32'(log_trans[4]), 32'h3);
    chk("t4 rv count", 32'(count_rv()), 32'd4);
    got.delete();
    for (int c = 0; c <= last_cyc; c++) if (log_rv[c]) got.push_back(log_rdata[c]);
    if (got.size() == 4) begin
      chk("t4 rd0", got[0], 32'hA000_0001);
      chk("t4 rd1", got[1], 32'hA000_0002);
      chk("t4 rd2", got[2], 32'hA000_0003);
      chk("t4 rd3", got[3], 32'hA000_0004);
    end
    chk("t4 done cycle", 32'(first_done()), 32'd8);

    // 5: address wrap-around
    fill_data(32'h5A5A_0000, 32'h0);
    run_cmd(1'b1, 32'hFFFF_FFFC, 1, 2, 0, 0, 1'b0);
    chk("t5 Haddr b1", log_addr[2], 32'h0000_0000);
    chk("t5 Hburst", 32'(log_burst[1]), 32'h1);

    // 7: INCR len 6, size clamped to word, wait on NONSEQ
    fill_data(32'h7700_0000, 32'h0);
    run_cmd(1'b1, 32'h0000_0100, 5, 7, 1, 1, 1'b0);
    chk("t7 Hsize clamp", 32'(log_size[1]), 32'h2);
    chk("t7 Haddr b5", log_addr[7], 32'h0000_0114);
    chk("t7 done cycle", 32'(first_done()), 32'd9);

    // 8: INCR16 halfword read, waits on the final data phase
    fill_data(32'h0, 32'hB000_0000);
    run_cmd(1'b0, 32'h0000_2000, 15, 1, 17, 3, 1'b0);
    chk("t8 Hburst", 32'(log_burst[1]), 32'h7);
    chk("t8 Haddr b15", log_addr[16], 32'h0000_201E);
    chk("t8 rv count", 32'(count_rv()), 32'd16);
    chk("t8 done cycle", 32'(first_done()), 32'd21);

    // 9: INCR8 byte write
    fill_data(32'h9900_0000, 32'h0);
    run_cmd(1'b1, 32'h0000_3FF0, 7, 0, 0, 0, 1'b0);
    chk("t9 Hburst", 32'(log_burst[1]), 32'h5);
    chk("t9 Haddr b7", log_addr[8], 32'h0000_3FF7);
    chk("t9 done cycle", 32'(first_done()), 32'd10);

    // 6: reset during beat 2 of an INCR8 read, then a fresh single read
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8000_0200;
    cmd_len = LEN_W'(7); cmd_size = 3'd2; Hreadyout = 1'b1; Hrdata = 32'hCAFE_0001;
    @(posedge Hclk); #1;
    cmd_valid = 1'b0;
    repeat (2) begin @(posedge Hclk); #1; end
    @(negedge Hclk);
    chk("t6 pre-reset Htrans", 32'(Htrans), 32'h3);
    chk("t6 pre-reset rd_valid", 32'(rd_valid), 32'd1);
    Hresetn = 1'b0;
    @(posedge Hclk); #1;
    Hresetn = 1'b1;
    @(negedge Hclk);
    check_all_zero("t6 after reset");
    @(posedge Hclk); #1;
    fill_data(32'h0, 32'h0BAD_F00D);
    run_cmd(1'b0, 32'h8000_0300, 0, 2, 0, 0, 1'b0);
    chk("t6 new read rd_data", log_rdata[3], 32'h0BAD_F00D);
    chk("t6 new read done", 32'(first_done()), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_master_seq.md
Name: ahb_master_seq

Overview:
- Command-driven AHB master sequencer. Converts a requester's single or incrementing-burst commands into pipelined AHB address/data phases on the AHB-to-APB bridge interface.
- Replaces hand-sequenced single_write/single_read stimulus with a synthesizable controller.
- Handles address/data phase overlap, Hreadyout wait states, write-data fetch and read-data return.

Parameters:
LEN_W, 4, width of cmd_len; burst length = cmd_len+1 beats (1..2^LEN_W)

Ports:
Hclk  in  1  clock, all logic on rising edge
Hresetn  in  1  synchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high when a command can be accepted (IDLE only)
cmd_write  in  1  1=write, 0=read
cmd_addr  in  32  start address
cmd_len  in  LEN_W  beats minus one
cmd_size  in  3  transfer size (0=byte,1=half,2=word)
wr_data  in  32  write data for current beat, sampled when wr_pop=1
wr_pop  out  1  write-data consume strobe, one per beat
rd_data  out  32  read data
rd_valid  out  1  one-cycle strobe per completed read beat
done  out  1  one-cycle strobe after last beat completes
Hreadyout  in  1  slave/bridge ready; 0 inserts wait state
Hrdata  in  32  AHB read data
Hwrite  out  1  AHB direction
Hreadyin  out  1  high while a command is in progress
Htrans  out  2  00 IDLE, 10 NONSEQ, 11 SEQ
Hsize  out  3  AHB size
Hburst  out  3  AHB burst type
Haddr  out  32  AHB address
Hwdata  out  32  AHB write data

Behaviour:
- Reset: synchronous on Hresetn=0 at rising Hclk, also mid-burst. All outputs 0: Htrans=00, Hwrite=0, Haddr=0, Hwdata=0, Hsize=0, Hburst=0, Hreadyin=0, rd_valid=0, done=0, wr_pop=0. cmd_ready=1 the cycle after reset. Aborted burst is not resumed.
- All AHB outputs are registered.
- States: IDLE, ADDR, PIPE, LAST.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid=1, latch command; next cycle enter ADDR with Htrans=10, Haddr=cmd_addr, Hwrite=cmd_write, Hsize, Hburst, Hreadyin=1.
- Hburst: len 0 -> 000 SINGLE; 3 -> 011 INCR4; 7 -> 101 INCR8; 15 -> 111 INCR16; other -> 001 INCR.
- Hsize: cmd_size>2 is clamped to 2.
- Address phase accepted = Htrans!=00 and Hreadyout=1 at the edge.
  - Next Haddr = Haddr + (1<<Hsize), modulo 2^32 (wraps, no error).
  - 1KB-boundary compliance is the requester's responsibility.
- ADDR/PIPE:
  - On acceptance with beats remaining, go to PIPE with Htrans=11.
  - On acceptance of the final address, go to LAST with Htrans=00.
  - PIPE = data phase of beat n overlapping address phase of beat n+1.
- LAST: data phase of the final beat. When Hreadyout=1: IDLE, Hreadyin=0, done=1 for one cycle.
- Write data:
  - wr_pop=1 (combinational) in the cycle an address phase is accepted.
  - wr_data is sampled that edge and driven on Hwdata the next cycle (data phase).
  - Hwdata holds through wait states.
- Read data: when a data phase completes with Hwrite=0 and Hreadyout=1, rd_data<=Hrdata and rd_valid=1 the following cycle.
- Wait states (Hreadyout=0): Haddr, Htrans, Hsize, Hburst, Hwdata and the state are all frozen. No wr_pop, no rd_valid.
- Counters: issued-beat counter (address phases) and completed-beat counter (data phases), each LEN_W+1 bits. Burst ends when completed = len+1.
- Latency:
  - Single transfer with no waits: accept at cycle 0; NONSEQ at cycle 1; data phase at cycle 2; done at cycle 3.
  - N-beat burst with no waits: done at cycle N+2.
- Throughput: minimum one IDLE cycle between commands (cmd_ready=0 from ADDR through LAST).
- Simultaneous events: a wait state on the last data phase delays done and the return to IDLE. cmd_valid outside IDLE is ignored (held by requester).

Test Plan:
1. Single write: addr 0x8000_0001, size 0, len 0, wr_data 0xA3, Hreadyout=1 -> cycle 1 Htrans=10, Hburst=000, Haddr=0x8000_0001, wr_pop=1; cycle 2 Htrans=00, Hwdata=0xA3; cycle 3 done=1, Hreadyin=0.
2. Single read: addr 0x8000_00A2, Hrdata=0x1234_5678 -> Hwrite=0, rd_valid=1 with rd_data=0x1234_5678 in cycle 3, done same cycle.
3. INCR4 word write: addr 0x8000_0010, len 3, size 2 -> Haddr 0x10, 0x14, 0x18, 0x1C; Htrans 10, 11, 11, 11, then 00; Hburst=011; four wr_pop; done at cycle 6.
4. Wait states: INCR4 read with Hreadyout=0 for 2 cycles during beat 2 data phase -> Haddr/Htrans held; rd_valid count=4 with data in order; done at cycle 8.
5. Wrap-around: addr 0xFFFF_FFFC, len 1, size 2 -> second Haddr=0x0000_0000; Hburst=001.
6. Reset mid-burst: Hresetn=0 during beat 2 of INCR8 -> next cycle all outputs 0, Htrans=00, cmd_ready=1; a new single read afterwards completes normally.
